axi_sram_slave: RTL

- Single-beat AXI3 slave RAM on the downstream side of the CPU's SRAM-to-AXI bridge.
- Consumes the bridge's AR/R/AW/W/B channels and backs them with a word-addressed register-array memory.
- Read and write latencies are programmable so the bridge and CPU can be exercised under multi-cycle memory delay.
- Read and write paths are independent FSMs sharing one storage array; each path has at most one outstanding transaction.

---
 rtl/axi_sram_slave.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 slave backed by a word-addressed register array, with
// programmable read/write response latency and independent read/write FSMs.
module axi_sram_slave #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  rd_state_dbg,
  output logic [1:0]  wr_state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a raised valid stays high with stable payload until that edge.

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wr_state_t;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  rd_state_t         rd_state, rd_next;
  logic [3:0]        rd_cnt;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] rd_sample_idx;
  logic              ar_hs;

  wr_state_t         wr_state, wr_next;
  logic [3:0]        wr_cnt;
  logic              aw_got, w_got;
  logic [ADDR_W-1:0] aw_idx_q;
  logic [3:0]        awid_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_hs, w_hs, commit;
  logic [ADDR_W-1:0] commit_idx;
  logic [31:0]       commit_data;
  logic [3:0]        commit_strb;
  logic [3:0]        commit_id;

  logic unused_ok;
  assign unused_ok = ^{arlen, arsize, awlen, awsize, wlast,
                       araddr[31:ADDR_W+2], araddr[1:0],
                       awaddr[31:ADDR_W+2], awaddr[1:0]};

  // ---------------- read path ----------------
  assign arready      = aresetn && (rd_state == R_IDLE);
  assign ar_hs        = arvalid && arready;
  assign rvalid       = (rd_state == R_DATA);
  assign rlast        = rvalid;
  assign rd_state_dbg = rd_state;

  // With zero latency the sample happens on the handshake edge itself.
  assign rd_sample_idx = (rd_state == R_IDLE) ? araddr[ADDR_W+1:2] : rd_idx;

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE: if (ar_hs) rd_next = (RD_LAT == 0) ? R_DATA : R_WAIT;
      R_WAIT: if (rd_cnt == 4'd0) rd_next = R_DATA;
      R_DATA: if (rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state <= R_IDLE;
      rd_cnt   <= 4'd0;
      rd_idx   <= '0;
      rid      <= 4'd0;
      rdata    <= 32'd0;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        rid    <= arid;
        rd_idx <= araddr[ADDR_W+1:2];
        rd_cnt <= 4'(RD_LAT - 1);
      end else if (rd_state == R_WAIT && rd_cnt != 4'd0) begin
        rd_cnt <= rd_cnt - 4'd1;
      end
      // Same-edge commit lands after this sample, so the read sees old data.
      if (rd_next == R_DATA && rd_state != R_DATA)
        rdata <= mem[rd_sample_idx];
    end
  end

  // ---------------- write path ----------------
  assign awready      = aresetn && (wr_state == W_IDLE) && !aw_got;
  assign wready       = aresetn && (wr_state == W_IDLE) && !w_got;
  assign aw_hs        = awvalid && awready;
  assign w_hs         = wvalid && wready;
  assign commit       = aresetn && (wr_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
  assign bvalid       = (wr_state == W_RESP);
  assign wr_state_dbg = wr_state;

  assign commit_idx  = aw_got ? aw_idx_q : awaddr[ADDR_W+1:2];
  assign commit_id   = aw_got ? awid_q   : awid;
  assign commit_data = w_got  ? wdata_q  : wdata;
  assign commit_strb = w_got  ? wstrb_q  : wstrb;

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE: if (commit) wr_next = (WR_LAT == 0) ? W_RESP : W_WAIT;
      W_WAIT: if (wr_cnt == 4'd0) wr_next = W_RESP;
      W_RESP: if (bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state <= W_IDLE;
      wr_cnt   <= 4'd0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      aw_idx_q <= '0;
      awid_q   <= 4'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      bid      <= 4'd0;
    end else begin
      wr_state <= wr_next;
      if (commit) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        bid    <= commit_id;
        wr_cnt <= 4'(WR_LAT - 1);
      end else begin
        if (aw_hs) begin
          aw_got   <= 1'b1;
          aw_idx_q <= awaddr[ADDR_W+1:2];
          awid_q   <= awid;
        end
        if (w_hs) begin
          w_got   <= 1'b1;
          wdata_q <= wdata;
          wstrb_q <= wstrb;
        end
        if (wr_state == W_WAIT && wr_cnt != 4'd0)
          wr_cnt <= wr_cnt - 4'd1;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge aclk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (commit_strb[b]) mem[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
      end
    end
  end

endmodule
